// File: rtl/image_stream_loader_pkg.sv
//==============================================================================
// image_stream_loader_pkg : shared constants, state encoding and sizing helpers
// Revision: 1.0
//==============================================================================
`default_nettype none

package image_stream_loader_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_D          = 1;
   localparam int DEF_H          = 30;
   localparam int DEF_W          = 30;
   localparam int N              = DEF_D * DEF_H * DEF_W;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } ldr_state_e;

   function automatic int pix_count(input int d, input int h, input int w);
      return d * h * w;
   endfunction

   // Never narrower than one bit, so a single-pixel image still has an index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/image_stream_loader_pixel_index_counter.sv
//==============================================================================
// pixel_index_counter : pixel index with enable, sync clear, wrap and TC flag
// Revision: 1.0
//==============================================================================
`default_nettype none

module pixel_index_counter
   import image_stream_loader_pkg::*;
#(
   parameter int NPIX  = N,
   parameter int IDX_W = idx_width(NPIX)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_at_last
);

   localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NPIX - 1);

   logic [IDX_W-1:0] r_idx;
   logic             w_at_last;

   assign w_at_last = (r_idx == C_LAST);

   // Clear wins over enable: an early-terminated frame restarts at pixel 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (i_clr) begin
         r_idx <= '0;
      end else if (i_en) begin
         r_idx <= w_at_last ? '0 : r_idx + 1'b1;
      end
   end

   assign o_idx     = r_idx;
   assign o_at_last = w_at_last;

endmodule

`default_nettype wire

// File: rtl/image_stream_loader.sv
//==============================================================================
// image_stream_loader : packs a pixel stream into a flat frame bus with handshake
// Revision: 1.0
//==============================================================================
`default_nettype none

module image_stream_loader
   import image_stream_loader_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int D          = DEF_D,
   parameter int H          = DEF_H,
   parameter int W          = DEF_W
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [DATA_WIDTH-1:0]          s_data,
   input  logic                           s_last,
   output logic [D*H*W*DATA_WIDTH-1:0]    image,
   output logic                           frame_valid,
   input  logic                           frame_ack,
   output logic                           err_len
);

   localparam int NPIX  = pix_count(D, H, W);
   localparam int IDX_W = idx_width(NPIX);
   localparam int IMG_W = NPIX * DATA_WIDTH;
   localparam int BASE_W = idx_width(IMG_W);

   ldr_state_e             r_state;
   ldr_state_e             w_state_nxt;
   logic [IMG_W-1:0]       r_image;
   logic                   r_err;
   logic [IDX_W-1:0]       w_idx;
   logic                   w_at_last;
   logic                   w_accept;
   logic                   w_early;
   logic                   w_missing;
   logic [BASE_W-1:0]      w_base;

   assign w_accept  = s_valid && (r_state == ST_FILL);
   assign w_early   = w_accept && s_last && !w_at_last;
   assign w_missing = w_accept && w_at_last && !s_last;
   assign w_base    = BASE_W'(w_idx) * BASE_W'(DATA_WIDTH);

   pixel_index_counter #(
      .NPIX  (NPIX),
      .IDX_W (IDX_W)
   ) u_idx (
      .clk       (clk),
      .rst_n     (reset),
      .i_en      (w_accept),
      .i_clr     (w_early),
      .o_idx     (w_idx),
      .o_at_last (w_at_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FILL: if (w_accept && w_at_last) w_state_nxt = ST_FULL;
         ST_FULL: if (frame_ack)             w_state_nxt = ST_FILL;
         default:                            w_state_nxt = ST_FILL;
      endcase
   end

   // Handshake outputs depend on the state register alone.
   always_comb begin
      s_ready     = 1'b0;
      frame_valid = 1'b0;
      case (r_state)
         ST_FILL: s_ready     = 1'b1;
         ST_FULL: frame_valid = 1'b1;
         default: s_ready     = 1'b0;
      endcase
   end

   // Pixels of a discarded partial frame stay until the next frame overwrites them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_image <= '0;
      end else if (w_accept) begin
         r_image[w_base +: DATA_WIDTH] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_early || w_missing;
      end
   end

   assign image   = r_image;
   assign err_len = r_err;

endmodule

`default_nettype wire

// File: doc/image_stream_loader.md
# image_stream_loader

Assembles a streamed input image, one pixel per accepted beat, into the flat `D*H*W*DATA_WIDTH` image bus consumed by the convolution layer. It sits directly in front of the conv layer and is the writer for the image bus that layer reads. It presents a complete, stable frame with `frame_valid` and holds it until the consumer acknowledges. It then releases the buffer for the next frame.

## Interface
- `DATA_WIDTH`, 16, bits per pixel
- `D`, 1, image depth (channels)
- `H`, 30, image height
- `W`, 30, image width
- `clk`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `s_valid`  in  1  pixel beat valid
- `s_ready`  out  1  loader can accept a beat
- `s_data`  in  DATA_WIDTH  pixel value
- `s_last`  in  1  marks final pixel of a frame
- `image`  out  D*H*W*DATA_WIDTH  assembled frame, flat
- `frame_valid`  out  1  `image` holds a complete frame
- `frame_ack`  in  1  consumer done with frame; release buffer
- `err_len`  out  1  one-cycle pulse on frame-length mismatch

## Operation
- N = D*H*W. Pixel index p counts 0..N-1.
- Stream order is channel-major, then row, then column: p = d*H*W + r*W + c.
- Accepted pixel p is written to `image[p*DATA_WIDTH +: DATA_WIDTH]`. This matches the conv layer's flattening.
- A beat is accepted when `s_valid && s_ready` at a rising edge.
- State FILL:
  - `s_ready`=1.
  - Each accepted beat writes the pixel at index p, then increments p.
- FILL → FULL: on acceptance of the beat with p==N-1, whether or not `s_last` is set.
  - On the same edge, p wraps to 0.
  - If `s_last`=0 on that beat, `err_len` pulses; the frame is still delivered.
- Early `s_last`: `s_last`=1 on an accepted beat with p<N-1.
  - Pulses `err_len`.
  - Discards the partial frame: p returns to 0 and the state stays FILL.
  - Already-written pixels are not cleared; the next frame overwrites them.
- State FULL:
  - `s_ready`=0 and `frame_valid`=1.
  - `image` bits are frozen.
- FULL → FILL: on `frame_ack`=1 at a rising edge.
- `frame_ack` in FILL is ignored.
- `s_valid` in FULL is ignored; nothing is written.
- `s_data` is don't-care when `s_valid`=0.
- Index register width: $clog2(N), minimum 1.
- No arithmetic on pixel data; values are stored verbatim.

## Timing
- Reset (asynchronous, while `reset`=0):
  - state FILL, p=0.
  - `s_ready`=1, `frame_valid`=0, `err_len`=0.
  - `image` = all zeros.
- `s_ready` and `frame_valid` are decoded from the state register only. Neither has a combinational path from any input.
- Last beat accepted at edge t:
  - From t, `frame_valid`=1 and `s_ready`=0.
  - The full frame is visible on `image` from the same edge.
- `frame_ack` sampled high at edge t: from t, `frame_valid`=0 and `s_ready`=1. The earliest next-frame beat is accepted at t+1.
- `frame_ack` held high continuously: releases once. Any further ack arriving while in FILL is ignored.
- Frame throughput: N cycles fill, plus 1 FULL cycle minimum, when ack is tied high.
- `err_len`: high for exactly the one cycle following the offending edge.
- Reset mid-fill or mid-FULL: returns immediately to the reset state and clears `image`. No partial frame is ever flagged valid.

## Structure
- Shared package:
  - Constant N = D*H*W.
  - Index-width function (clog2).
  - State encoding constants FILL/FULL.
  - Reused by an output-side streamer for the conv result bus.
- One sub-module, `pixel_index_counter`: a clog2(N)-bit counter providing the following:
  - increment enable;
  - synchronous clear (used for early `s_last`);
  - wrap at N-1;
  - terminal-count flag `at_last`.
- The top level holds the state register, the write decoder (indexed part-select) and `err_len`.

## Test plan
- **Basic fill:** D=1, H=W=3; stream values 1..9 with `s_valid`=1 and `s_last` on the 9th beat.
  - Required: `frame_valid`=1 on the edge after the 9th beat.
  - `image[p*16 +: 16]` = p+1 for all p; `err_len` stays 0.
- **Backpressure:** while FULL, drive `s_valid`=1 with data 0xFFFF for 5 cycles.
  - Required: `s_ready`=0 throughout and `image` unchanged.
  - Then `frame_ack`=1 for one cycle; `s_ready`=1 on the next cycle.
- **Early last:** `s_last` on the 4th beat of a 9-pixel frame.
  - Required: one-cycle `err_len` pulse; `frame_valid` stays 0.
  - Then 9 fresh beats (10..18) deliver `image` = 10..18.
- **Missing last:** 9 beats with `s_last`=0.
  - Required: `err_len` pulse and `frame_valid`=1 on the same cycle; frame contents correct.
- **Async reset mid-fill:** drop `reset` to 0 between clock edges after 5 beats.
  - Required: outputs go to reset values immediately, before the next edge.
  - After release, a full 9-beat frame loads correctly starting at p=0.
- **Back-to-back:** ack tied high, two frames streamed with `s_valid` gaps.
  - Required: each frame shows `frame_valid` for exactly 1 cycle.
  - No beat is accepted while `s_ready`=0; second frame contents are correct.
